// File: rtl/fp_to_int_pkg.sv
// Shared constants for the binary32 -> integer converter: conversion codes,
// field widths, operand classes and per-format saturation values.
package fp_to_int_pkg;

    localparam logic [1:0] CONV_S32 = 2'b00;
    localparam logic [1:0] CONV_U32 = 2'b01;
    localparam logic [1:0] CONV_S64 = 2'b10;
    localparam logic [1:0] CONV_U64 = 2'b11;

    localparam int FP32_EXP_W  = 8;
    localparam int FP32_FRAC_W = 23;
    localparam int FP32_SIG_W  = FP32_FRAC_W + 1;
    localparam logic [FP32_EXP_W-1:0] EXP_BIAS = 8'd127;

    // 32-bit limits are stored already sign-extended into 64 bits
    localparam logic [63:0] S32_MAX = 64'h0000_0000_7FFF_FFFF;
    localparam logic [63:0] S32_MIN = 64'hFFFF_FFFF_8000_0000;
    localparam logic [63:0] U32_MAX = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] S64_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] S64_MIN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] U64_MAX = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        CLS_ZERO   = 2'd0,
        CLS_NORMAL = 2'd1,
        CLS_INF    = 2'd2,
        CLS_NAN    = 2'd3
    } fp_class_t;

    function automatic logic [63:0] conv_max(input logic [1:0] c);
        case (c)
            CONV_S32: conv_max = S32_MAX;
            CONV_U32: conv_max = U32_MAX;
            CONV_S64: conv_max = S64_MAX;
            default:  conv_max = U64_MAX;
        endcase
    endfunction

    function automatic logic [63:0] conv_min(input logic [1:0] c);
        case (c)
            CONV_S32: conv_min = S32_MIN;
            CONV_S64: conv_min = S64_MIN;
            default:  conv_min = 64'd0;
        endcase
    endfunction

endpackage

// File: rtl/fp32_align_shift.sv
// Combinational alignment of a 24-bit significand to an integer magnitude,
// truncating toward zero and reporting whether any discarded bit was set.
module fp32_align_shift
    import fp_to_int_pkg::*;
(
    input  logic [FP32_SIG_W-1:0] sig,
    input  logic [FP32_EXP_W-1:0] exp,
    output logic [63:0]           mag,
    output logic                  sticky
);

    logic       shift_left;
    logic [7:0] lsh_full;
    logic [7:0] rsh_full;
    logic [5:0] lsh;
    logic [5:0] rsh;

    assign shift_left = (exp >= 8'd150);
    assign lsh_full   = exp - 8'd150;
    assign rsh_full   = 8'd150 - exp;
    // Left shifts past 40 only occur on overflow, and a right shift of 32
    // already moves every significand bit below the binary point.
    assign lsh = (lsh_full > 8'd63) ? 6'd63 : lsh_full[5:0];
    assign rsh = (rsh_full > 8'd32) ? 6'd32 : rsh_full[5:0];

    logic [63:0] lstage [0:6];
    logic [55:0] rstage [0:6];

    assign lstage[0] = {40'd0, sig};
    assign rstage[0] = {sig, 32'd0};

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_barrel
            localparam int SH = 1 << gi;
            assign lstage[gi+1] = lsh[gi] ? {lstage[gi][63-SH:0], {SH{1'b0}}} : lstage[gi];
            assign rstage[gi+1] = rsh[gi] ? {{SH{1'b0}}, rstage[gi][55:SH]} : rstage[gi];
        end
    endgenerate

    always_comb begin
        mag    = 64'd0;
        sticky = 1'b0;
        if (shift_left) begin
            mag = lstage[6];
        end else begin
            mag    = {40'd0, rstage[6][55:32]};
            sticky = |rstage[6][31:0];
        end
    end

endmodule

// File: rtl/floating_point_to_int.sv
// Two-stage binary32 -> signed/unsigned 32/64-bit integer converter with
// truncation and saturation. Define FTOI_INEXACT_EN to add inexact_flag.
module floating_point_to_int
    import fp_to_int_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] float,
    input  logic [1:0]  conv,
    output logic        invalid_op_flag,
    output logic [63:0] int_result
`ifdef FTOI_INEXACT_EN
    ,
    output logic        inexact_flag
`endif
);

    // Stage 1: unpack and classify
    logic [FP32_EXP_W-1:0]  f_exp;
    logic [FP32_FRAC_W-1:0] f_frac;
    fp_class_t              cls_next;

    assign f_exp  = float[30:23];
    assign f_frac = float[22:0];

    always_comb begin
        cls_next = CLS_NORMAL;
        if (f_exp == 8'h00) begin
            cls_next = CLS_ZERO;
        end else if (f_exp == 8'hFF) begin
            cls_next = (f_frac != '0) ? CLS_NAN : CLS_INF;
        end
    end

    logic                  sign_reg;
    logic [FP32_EXP_W-1:0] exp_reg;
    logic [FP32_SIG_W-1:0] sig_reg;
    fp_class_t             cls_reg;
    logic [1:0]            conv_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sign_reg <= 1'b0;
            exp_reg  <= '0;
            sig_reg  <= '0;
            cls_reg  <= CLS_ZERO;
            conv_reg <= CONV_S32;
        end else begin
            sign_reg <= float[31];
            exp_reg  <= f_exp;
            // Hidden bit is zero for denormals, so sig_reg != 0 flags a denormal
            sig_reg  <= {(f_exp != 8'h00), f_frac};
            cls_reg  <= cls_next;
            conv_reg <= conv;
        end
    end

    // Stage 2: align, negate, saturate
    logic [63:0] mag;
    logic        sticky;

    fp32_align_shift u_align (
        .sig    (sig_reg),
        .exp    (exp_reg),
        .mag    (mag),
        .sticky (sticky)
    );

    logic        is64;
    logic        is_signed;
    logic [7:0]  ovf_exp;
    logic        exact_min;
    logic        overflow;
    logic [63:0] fmt_max;
    logic [63:0] fmt_min;

    assign is64      = conv_reg[1];
    assign is_signed = ~conv_reg[0];
    assign ovf_exp   = is64 ? 8'd191 : 8'd159;
    assign exact_min = sign_reg && (sig_reg == 24'h80_0000);
    // One exponent below the unsigned limit only the exact minimum fits signed
    assign overflow  = (exp_reg >= ovf_exp) ||
                       (is_signed && (exp_reg == ovf_exp - 8'd1) && !exact_min);
    assign fmt_max   = conv_max(conv_reg);
    assign fmt_min   = conv_min(conv_reg);

    logic [63:0] raw_next;
    logic [63:0] result_next;
    logic        invalid_next;

    always_comb begin
        raw_next     = 64'd0;
        invalid_next = 1'b0;
        case (cls_reg)
            CLS_NAN: begin
                raw_next     = fmt_max;
                invalid_next = 1'b1;
            end
            CLS_INF: begin
                raw_next     = sign_reg ? fmt_min : fmt_max;
                invalid_next = 1'b1;
            end
            CLS_NORMAL: begin
                if (is_signed) begin
                    if (overflow) begin
                        raw_next     = sign_reg ? fmt_min : fmt_max;
                        invalid_next = 1'b1;
                    end else begin
                        raw_next = sign_reg ? (64'd0 - mag) : mag;
                    end
                end else if (sign_reg) begin
                    raw_next     = 64'd0;
                    invalid_next = (exp_reg >= EXP_BIAS);
                end else if (overflow) begin
                    raw_next     = fmt_max;
                    invalid_next = 1'b1;
                end else begin
                    raw_next = mag;
                end
            end
            default: begin
                raw_next     = 64'd0;
                invalid_next = 1'b0;
            end
        endcase
    end

    assign result_next = is64 ? raw_next : {{32{raw_next[31]}}, raw_next[31:0]};

    logic [63:0] int_result_reg;
    logic        invalid_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            int_result_reg <= 64'd0;
            invalid_reg    <= 1'b0;
        end else begin
            int_result_reg <= result_next;
            invalid_reg    <= invalid_next;
        end
    end

    assign int_result      = int_result_reg;
    assign invalid_op_flag = invalid_reg;

`ifdef FTOI_INEXACT_EN
    logic inexact_next;
    logic inexact_reg;

    // A normal operand saturates exactly when it is invalid
    always_comb begin
        inexact_next = 1'b0;
        if (cls_reg == CLS_ZERO) begin
            inexact_next = |sig_reg;
        end else if (cls_reg == CLS_NORMAL) begin
            inexact_next = sticky && !invalid_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inexact_reg <= 1'b0;
        end else begin
            inexact_reg <= inexact_next;
        end
    end

    assign inexact_flag = inexact_reg;
`endif

endmodule

// File: tb/tb_floating_point_to_int.sv
// Self-checking bench for floating_point_to_int: expected results are queued
// when an operand is driven and compared when it leaves the pipeline.
module tb_floating_point_to_int;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] float_op;
    logic [1:0]  conv;
    logic        invalid_op_flag;
    logic [63:0] int_result;
`ifdef FTOI_INEXACT_EN
    logic        inexact_flag;
`endif

    floating_point_to_int dut (
        .clk             (clk),
        .reset           (reset),
        .float           (float_op),
        .conv            (conv),
        .invalid_op_flag (invalid_op_flag),
        .int_result      (int_result)
`ifdef FTOI_INEXACT_EN
        ,
        .inexact_flag    (inexact_flag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] f;
        logic [1:0]  c;
        logic [63:0] v;
        logic        inv;
        logic        inx;
    } vec_t;

    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Operands driven at negedge c emerge by negedge c+2
    task automatic test_vectors(input string name, input vec_t vecs[]);
        vec_t e;
        for (int c = 0; c < vecs.size() + 2; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                e = sb.pop_front();
                $display("txn %s float=%h conv=%b int=%h invalid=%b", name, e.f, e.c, int_result, invalid_op_flag);
                n_checks++;
                if (int_result !== e.v) begin
                    n_fail++;
                    $display("FAIL %s int float=%h conv=%b actual=%h required=%h", name, e.f, e.c, int_result, e.v);
                end
                n_checks++;
                if (invalid_op_flag !== e.inv) begin
                    n_fail++;
                    $display("FAIL %s invalid float=%h conv=%b actual=%b required=%b", name, e.f, e.c, invalid_op_flag, e.inv);
                end
`ifdef FTOI_INEXACT_EN
                n_checks++;
                if (inexact_flag !== e.inx) begin
                    n_fail++;
                    $display("FAIL %s inexact float=%h conv=%b actual=%b required=%b", name, e.f, e.c, inexact_flag, e.inx);
                end
`endif
            end
            if (c < vecs.size()) begin
                float_op = vecs[c].f;
                conv     = vecs[c].c;
                sb.push_back(vecs[c]);
            end
        end
    endtask

    task automatic test_reset();
        vec_t e;
        reset    = 1'b1;
        float_op = 32'hC4EF956C;
        conv     = 2'b10;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            $display("txn reset edge=%0d int=%h invalid=%b", i, int_result, invalid_op_flag);
            n_checks++;
            if (int_result !== 64'd0 || invalid_op_flag !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold edge=%0d actual=%h/%b required=0/0", i, int_result, invalid_op_flag);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        sb.push_back('{32'hC4EF956C, 2'b10, 64'hFFFF_FFFF_FFFF_F884, 1'b0, 1'b1});
        @(negedge clk);
        @(negedge clk);
        e = sb.pop_front();
        $display("txn reset_release float=%h int=%h invalid=%b", e.f, int_result, invalid_op_flag);
        n_checks++;
        if (int_result !== e.v || invalid_op_flag !== e.inv) begin
            n_fail++;
            $display("FAIL reset_release actual=%h/%b required=%h/%b", int_result, invalid_op_flag, e.v, e.inv);
        end
`ifdef FTOI_INEXACT_EN
        n_checks++;
        if (inexact_flag !== e.inx) begin
            n_fail++;
            $display("FAIL reset_release inexact actual=%b required=%b", inexact_flag, e.inx);
        end
`endif
    endtask

    task automatic test_signed_boundaries();
        vec_t v[] = new[10];
        v[0] = '{32'h4F000000, 2'b00, 64'h0000_0000_7FFF_FFFF, 1'b1, 1'b0};
        v[1] = '{32'h4F000000, 2'b10, 64'h0000_0000_8000_0000, 1'b0, 1'b0};
        v[2] = '{32'h4F000000, 2'b01, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0};
        v[3] = '{32'hCF000000, 2'b00, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0};
        v[4] = '{32'hDF000000, 2'b10, 64'h8000_0000_0000_0000, 1'b0, 1'b0};
        v[5] = '{32'hCF000001, 2'b00, 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0};
        v[6] = '{32'h5F000000, 2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        v[7] = '{32'h5F000000, 2'b11, 64'h8000_0000_0000_0000, 1'b0, 1'b0};
        v[8] = '{32'h5F800000, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        v[9] = '{32'h4F7FFFFF, 2'b01, 64'hFFFF_FFFF_FFFF_FF00, 1'b0, 1'b0};
        test_vectors("boundary", v);
    endtask

    task automatic test_specials();
        vec_t v[] = new[7];
        v[0] = '{32'h7FC00000, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        v[1] = '{32'hFF800000, 2'b10, 64'h8000_0000_0000_0000, 1'b1, 1'b0};
        v[2] = '{32'h7FC00000, 2'b00, 64'h0000_0000_7FFF_FFFF, 1'b1, 1'b0};
        v[3] = '{32'hFFC00001, 2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        v[4] = '{32'h7F800000, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        v[5] = '{32'hFF800000, 2'b01, 64'h0000_0000_0000_0000, 1'b1, 1'b0};
        v[6] = '{32'h80000000, 2'b00, 64'h0000_0000_0000_0000, 1'b0, 1'b0};
        test_vectors("special", v);
    endtask

    task automatic test_fractions();
        vec_t v[] = new[5];
        v[0] = '{32'hBF000000, 2'b01, 64'h0, 1'b0, 1'b1};
        v[1] = '{32'hBF800000, 2'b01, 64'h0, 1'b1, 1'b0};
        v[2] = '{32'h3FC00000, 2'b00, 64'h1, 1'b0, 1'b1};
        v[3] = '{32'hC0200000, 2'b00, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1};
        v[4] = '{32'h4F800000, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        test_vectors("fraction", v);
    endtask

    task automatic test_back_to_back();
        vec_t v[] = new[3];
        v[0] = '{32'h3F800000, 2'b10, 64'h1, 1'b0, 1'b0};
        v[1] = '{32'h40000000, 2'b10, 64'h2, 1'b0, 1'b0};
        v[2] = '{32'h00000001, 2'b10, 64'h0, 1'b0, 1'b1};
        test_vectors("stream", v);

        // Fill the pipe with nonzero results, then reset mid-stream
        float_op = 32'h40400000;
        conv     = 2'b10;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (int_result !== 64'd3) begin
            n_fail++;
            $display("FAIL midreset_pre actual=%h required=%h", int_result, 64'd3);
        end
        reset = 1'b1;
        @(negedge clk);
        $display("txn midreset int=%h invalid=%b", int_result, invalid_op_flag);
        n_checks++;
        if (int_result !== 64'd0 || invalid_op_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset actual=%h/%b required=0/0", int_result, invalid_op_flag);
        end
        reset = 1'b0;
        sb.delete();
        v = new[2];
        v[0] = '{32'hC2F60000, 2'b00, 64'hFFFF_FFFF_FFFF_FF85, 1'b0, 1'b0};
        v[1] = '{32'h42F60000, 2'b11, 64'd123, 1'b0, 1'b0};
        test_vectors("post_reset", v);
    endtask

    initial begin
        test_reset();
        test_signed_boundaries();
        test_specials();
        test_fractions();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
